// File: rtl/lbseq_pkg.sv
// Shared types and constants for the line-buffer sequencer.
// LBSEQ_FLUSH_EN (optional macro) adds the FLUSH state that drains the last
// two centre rows by writing zero rows into the line buffer.
package lbseq_pkg;

  // Rows written before the first 5x5 window is complete
  localparam int unsigned LBSEQ_FILL_ROWS  = 4;
  // Zero rows pushed after the frame to emit the bottom two centre rows
  localparam int unsigned LBSEQ_FLUSH_ROWS = 2;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_FILL  = 3'd1,
    ST_RUN   = 3'd2,
`ifdef LBSEQ_FLUSH_EN
    ST_FLUSH = 3'd3,
`endif
    ST_DONE  = 3'd4
  } lbseq_state_t;

endpackage

// File: rtl/lbseq_pos_counter.sv
// Raster position counter: col wraps at IMG_WIDTH-1 and bumps row; row wraps
// at IMG_HEIGHT-1. clear has priority over step.
// Ports: clk, rst_n, clear, step -> row, col, last_col, last_pix.
module lbseq_pos_counter #(
  parameter int unsigned IMG_WIDTH  = 128,
  parameter int unsigned IMG_HEIGHT = 128
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          clear,
  input  logic                          step,
  output logic [$clog2(IMG_HEIGHT)-1:0] row,
  output logic [$clog2(IMG_WIDTH)-1:0]  col,
  output logic                          last_col,
  output logic                          last_pix
);

  localparam int unsigned RW = $clog2(IMG_HEIGHT);
  localparam int unsigned CW = $clog2(IMG_WIDTH);

  logic last_row;

  assign last_col = (col == CW'(IMG_WIDTH - 1));
  assign last_row = (row == RW'(IMG_HEIGHT - 1));
  assign last_pix = last_col && last_row;

  // Position register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      row <= '0;
      col <= '0;
    end else if (clear) begin
      row <= '0;
      col <= '0;
    end else if (step) begin
      if (last_col) begin
        col <= '0;
        row <= last_row ? '0 : RW'(row + RW'(1));
      end else begin
        col <= CW'(col + CW'(1));
      end
    end
  end

endmodule

// File: rtl/line_buffer_sequencer.sv
// Sequences a pixel stream into a 5-row line buffer and tags each completed
// 5x5 window with its centre coordinates.
// Optional macro LBSEQ_FLUSH_EN: after the last pixel, push two zero rows so
// the bottom two centre rows are also emitted; otherwise RUN ends in DONE.
// Ports:
//   clk, rst_n                      clock, async active-low reset
//   start                           frame start request (honoured in IDLE only)
//   s_valid, s_data, s_ready        upstream pixel stream
//   lb_valid_in, lb_din             write port of the line buffer
//   lb_window_valid                 line buffer holds 5 valid rows
//   m_ready                         downstream filter accepts a window
//   win_valid, win_row, win_col     window strobe and centre coordinates
//   busy, frame_done, sync_err      status (sync_err is sticky)
module line_buffer_sequencer
  import lbseq_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned IMG_WIDTH  = 128,
  parameter int unsigned IMG_HEIGHT = 128
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          start,
  input  logic                          s_valid,
  input  logic [DATA_WIDTH-1:0]         s_data,
  output logic                          s_ready,
  output logic                          lb_valid_in,
  output logic [DATA_WIDTH-1:0]         lb_din,
  input  logic                          lb_window_valid,
  input  logic                          m_ready,
  output logic                          win_valid,
  output logic [$clog2(IMG_HEIGHT)-1:0] win_row,
  output logic [$clog2(IMG_WIDTH)-1:0]  win_col,
  output logic                          busy,
  output logic                          frame_done,
  output logic                          sync_err
);

  localparam int unsigned RW = $clog2(IMG_HEIGHT);
  localparam int unsigned CW = $clog2(IMG_WIDTH);

  lbseq_state_t    state_q;
  lbseq_state_t    state_d;
  logic [RW-1:0]   row;
  logic [CW-1:0]   col;
  logic            last_col;
  logic            last_pix;
  logic            cnt_clear;
  logic            cnt_step;

  lbseq_pos_counter #(
    .IMG_WIDTH  (IMG_WIDTH),
    .IMG_HEIGHT (IMG_HEIGHT)
  ) u_pos (
    .clk      (clk),
    .rst_n    (rst_n),
    .clear    (cnt_clear),
    .step     (cnt_step),
    .row      (row),
    .col      (col),
    .last_col (last_col),
    .last_pix (last_pix)
  );

  // State and sticky error register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= ST_IDLE;
      sync_err <= 1'b0;
    end else begin
      state_q <= state_d;
      if (win_valid && !lb_window_valid) begin
        sync_err <= 1'b1;
      end
    end
  end

  assign busy       = (state_q != ST_IDLE);
  assign frame_done = (state_q == ST_DONE);

  // Next state, handshake and window outputs
  always_comb begin
    state_d     = state_q;
    s_ready     = 1'b0;
    lb_valid_in = 1'b0;
    lb_din      = '0;
    win_valid   = 1'b0;
    win_row     = '0;
    win_col     = '0;
    cnt_clear   = 1'b0;
    cnt_step    = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (start) begin
          cnt_clear = 1'b1;
          state_d   = ST_FILL;
        end
      end

      ST_FILL: begin
        s_ready = 1'b1;
        if (s_valid) begin
          lb_valid_in = 1'b1;
          lb_din      = s_data;
          cnt_step    = 1'b1;
          if (last_col && (row == RW'(LBSEQ_FILL_ROWS - 1))) begin
            state_d = ST_RUN;
          end
        end
      end

      ST_RUN: begin
        // Centre row trails the write row by half the window height
        s_ready = m_ready;
        win_row = RW'(row - RW'(LBSEQ_FILL_ROWS / 2));
        win_col = col;
        if (s_valid && m_ready) begin
          lb_valid_in = 1'b1;
          lb_din      = s_data;
          win_valid   = 1'b1;
          cnt_step    = 1'b1;
          if (last_pix) begin
            cnt_clear = 1'b1;
`ifdef LBSEQ_FLUSH_EN
            state_d   = ST_FLUSH;
`else
            state_d   = ST_DONE;
`endif
          end
        end
      end

`ifdef LBSEQ_FLUSH_EN
      ST_FLUSH: begin
        // Counter restarted at 0; centre rows continue from IMG_HEIGHT-2
        lb_valid_in = m_ready;
        win_valid   = m_ready;
        win_row     = RW'(RW'(IMG_HEIGHT - LBSEQ_FLUSH_ROWS) + row);
        win_col     = col;
        if (m_ready) begin
          cnt_step = 1'b1;
          if (last_col && (row == RW'(LBSEQ_FLUSH_ROWS - 1))) begin
            cnt_clear = 1'b1;
            state_d   = ST_DONE;
          end
        end
      end
`endif

      ST_DONE: begin
        state_d = ST_IDLE;
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

endmodule
